// File: rtl/pcie_tx_pkg.sv
// Purpose : shared owner/state encodings, sync headers and SKP symbols for the TX block scheduler.
// Latency : n/a (types, constants and pure helper functions only).
// Backpr. : n/a.
package pcie_tx_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_SKP  = 2'd1,
    OWN_OS   = 2'd2,
    OWN_DATA = 2'd3
  } owner_e;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SKP      = 3'd2,
    ST_OS       = 3'd3,
    ST_DATA     = 3'd4
  } sched_state_e;

  localparam logic [1:0] SYNC_OS   = 2'b01;
  localparam logic [1:0] SYNC_DATA = 2'b10;

  localparam logic [7:0] SKP_AA  = 8'hAA;
  localparam logic [7:0] SKP_E1  = 8'hE1;
  localparam logic [7:0] SKP_COM = 8'hBC;
  localparam logic [7:0] SKP_1C  = 8'h1C;

  function automatic logic gen_valid(input logic [2:0] g);
    return (g >= 3'd1) && (g <= 3'd5);
  endfunction

  // Beats per block: 4 bytes/block at gen1/2, 16 bytes/block at gen3+.
  function automatic logic [3:0] beats_per_block(input logic [2:0] g);
    return (g == 3'd3) ? 4'd8 : 4'd4;
  endfunction

  // Lanes of the 32-bit beat that carry real bytes at this rate.
  function automatic logic [31:0] byte_mask(input logic [2:0] g);
    if (g >= 3'd4)      return 32'hFFFF_FFFF;
    else if (g == 3'd3) return 32'h0000_FFFF;
    else                return 32'h0000_00FF;
  endfunction

endpackage

// File: rtl/skp_block_gen.sv
// Purpose : SKP ordered-set symbols for the current beat of an SKP block.
// Latency : combinational.
// Backpr. : none; caller decides when the beat is used.
// Ports   : generation/beat_cnt in -> skp_data (32b, byte 0 in [7:0]) / skp_datak out.
module skp_block_gen
  import pcie_tx_pkg::*;
(
  input  logic [2:0]  generation,
  input  logic [3:0]  beat_cnt,
  output logic [31:0] skp_data,
  output logic [3:0]  skp_datak
);

  // 128b/130b SKP: 12 x AA, then SKP_END (E1), then three zero bytes.
  function automatic logic [7:0] skp_byte(input logic [5:0] idx);
    if (idx < 6'd12)       return SKP_AA;
    else if (idx == 6'd12) return SKP_E1;
    else                   return 8'h00;
  endfunction

  always_comb begin
    skp_data  = '0;
    skp_datak = '0;
    if (generation <= 3'd2) begin
      skp_data[7:0] = (beat_cnt == 4'd0) ? SKP_COM : SKP_1C;
      skp_datak[0]  = 1'b1;
    end else if (generation == 3'd3) begin
      skp_data[7:0]  = skp_byte({1'b0, beat_cnt, 1'b0});
      skp_data[15:8] = skp_byte({1'b0, beat_cnt, 1'b1});
    end else begin
      for (int i = 0; i < 4; i++) begin
        skp_data[8*i +: 8] = skp_byte({beat_cnt, 2'b00} + 6'(i));
      end
    end
  end

endmodule

// File: rtl/tx_block_scheduler.sv
// Purpose : per-block arbiter SKP > ordered-set > link-data > idle feeding the scrambler.
// Latency : one cycle from accepted beat to registered sched_* outputs.
// Backpr. : ready is high only for the block owner; owner dropping valid mid-block emits a zero beat.
// Ports   : pclk/reset_n; generation, skp_interval; os_* and ld_* requesters (valid/ready);
//           sched_data/datak/sync_header/data_valid to scrambler; cur_owner, err_underflow status.
module tx_block_scheduler
  import pcie_tx_pkg::*;
(
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [2:0]  generation,
  input  logic [10:0] skp_interval,
  input  logic        os_valid,
  input  logic [31:0] os_data,
  input  logic [3:0]  os_datak,
  output logic        os_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [31:0] sched_data,
  output logic [3:0]  sched_datak,
  output logic [1:0]  sched_sync_header,
  output logic        sched_data_valid,
  output logic [1:0]  cur_owner,
  output logic        err_underflow
);

  sched_state_e state_q, state_d, beat_st;
  logic [2:0]   gen_q, gen_d, gen_eff;
  logic [3:0]   beat_cnt_q, beat_cnt_d;
  logic [10:0]  blk_cnt_q, blk_cnt_d;
  logic         skp_pending_q, skp_pending_d;
  logic [31:0]  data_q, data_d;
  logic [3:0]   datak_q, datak_d;
  logic [1:0]   sync_q, sync_d;
  logic         vld_q, vld_d;
  logic [1:0]   owner_q, owner_d;
  logic         uflow_q, uflow_d;
  logic         boundary, block_end;
  logic [31:0]  mask;
  logic [31:0]  skp_data;
  logic [3:0]   skp_datak;

  // At a boundary the live generation input applies to this beat; mid-block the latched one does.
  assign boundary = (beat_cnt_q == 4'd0);
  assign gen_eff  = boundary ? generation : gen_q;

  skp_block_gen u_skp_block_gen (
    .generation (gen_eff),
    .beat_cnt   (beat_cnt_q),
    .skp_data   (skp_data),
    .skp_datak  (skp_datak)
  );

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_DISABLED;
      gen_q         <= '0;
      beat_cnt_q    <= '0;
      blk_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
      data_q        <= '0;
      datak_q       <= '0;
      sync_q        <= '0;
      vld_q         <= 1'b0;
      owner_q       <= '0;
      uflow_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      gen_q         <= gen_d;
      beat_cnt_q    <= beat_cnt_d;
      blk_cnt_q     <= blk_cnt_d;
      skp_pending_q <= skp_pending_d;
      data_q        <= data_d;
      datak_q       <= datak_d;
      sync_q        <= sync_d;
      vld_q         <= vld_d;
      owner_q       <= owner_d;
      uflow_q       <= uflow_d;
    end
  end

  always_comb begin
    beat_st       = state_q;
    state_d       = state_q;
    gen_d         = gen_q;
    beat_cnt_d    = beat_cnt_q;
    blk_cnt_d     = blk_cnt_q;
    skp_pending_d = skp_pending_q;
    data_d        = '0;
    datak_d       = '0;
    sync_d        = 2'b00;
    vld_d         = 1'b0;
    owner_d       = OWN_IDLE;
    uflow_d       = 1'b0;
    os_ready      = 1'b0;
    ld_ready      = 1'b0;
    block_end     = 1'b0;
    mask          = byte_mask(gen_eff);

    // Arbitration happens only in the beat-0 cycle; the winner holds the whole block.
    if (boundary) begin
      gen_d = generation;
      if (!gen_valid(generation)) beat_st = ST_DISABLED;
      else if (skp_pending_q)     beat_st = ST_SKP;
      else if (os_valid)          beat_st = ST_OS;
      else if (ld_valid)          beat_st = ST_DATA;
      else                        beat_st = ST_IDLE;
    end
    state_d = beat_st;

    case (beat_st)
      ST_SKP: begin
        owner_d = OWN_SKP;
        data_d  = skp_data;
        datak_d = skp_datak;
      end
      ST_OS: begin
        owner_d  = OWN_OS;
        os_ready = reset_n;
        if (os_valid) begin
          data_d  = os_data & mask;
          datak_d = (gen_eff <= 3'd2) ? (os_datak & 4'b0001) : 4'b0000;
        end else begin
          uflow_d = 1'b1;
        end
      end
      ST_DATA: begin
        owner_d  = OWN_DATA;
        ld_ready = reset_n;
        if (ld_valid) data_d = ld_data & mask;
        else          uflow_d = 1'b1;
      end
      default: owner_d = OWN_IDLE;
    endcase

    if (beat_st != ST_DISABLED) begin
      vld_d = 1'b1;
      if (boundary && (gen_eff >= 3'd3)) begin
        sync_d = ((beat_st == ST_SKP) || (beat_st == ST_OS)) ? SYNC_OS : SYNC_DATA;
      end
      block_end  = (beat_cnt_q == (beats_per_block(gen_eff) - 4'd1));
      beat_cnt_d = block_end ? 4'd0 : beat_cnt_q + 4'd1;
      // SKP blocks restart the interval and are not themselves counted.
      if (boundary && (beat_st == ST_SKP)) begin
        blk_cnt_d     = '0;
        skp_pending_d = 1'b0;
      end else if (block_end && (beat_st != ST_SKP)) begin
        blk_cnt_d = blk_cnt_q + 11'd1;
        if ((skp_interval != 11'd0) && (blk_cnt_d == skp_interval)) skp_pending_d = 1'b1;
      end
    end
  end

  assign sched_data        = data_q;
  assign sched_datak       = datak_q;
  assign sched_sync_header = sync_q;
  assign sched_data_valid  = vld_q;
  assign cur_owner         = owner_q;
  assign err_underflow     = uflow_q;

endmodule

// File: tb/tb_tx_block_scheduler.sv
module tb_tx_block_scheduler;
  logic        pclk;
  logic        reset_n;
  logic [2:0]  generation;
  logic [10:0] skp_interval;
  logic        os_valid;
  logic [31:0] os_data;
  logic [3:0]  os_datak;
  logic        os_ready;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [31:0] sched_data;
  logic [3:0]  sched_datak;
  logic [1:0]  sched_sync_header;
  logic        sched_data_valid;
  logic [1:0]  cur_owner;
  logic        err_underflow;

  tx_block_scheduler dut (
    .pclk              (pclk),
    .reset_n           (reset_n),
    .generation        (generation),
    .skp_interval      (skp_interval),
    .os_valid          (os_valid),
    .os_data           (os_data),
    .os_datak          (os_datak),
    .os_ready          (os_ready),
    .ld_valid          (ld_valid),
    .ld_data           (ld_data),
    .ld_ready          (ld_ready),
    .sched_data        (sched_data),
    .sched_datak       (sched_datak),
    .sched_sync_header (sched_sync_header),
    .sched_data_valid  (sched_data_valid),
    .cur_owner         (cur_owner),
    .err_underflow     (err_underflow)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        rst;
    logic [2:0]  gen;
    logic        os_v;
    logic [31:0] os_d;
    logic [3:0]  os_k;
    logic        ld_v;
    logic [31:0] ld_d;
    logic        os_rdy;
    logic        ld_rdy;
    logic [31:0] data;
    logic [3:0]  k;
    logic [1:0]  hdr;
    logic        vld;
    logic [1:0]  own;
    logic        uf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  k;
    logic [1:0]  hdr;
    logic        vld;
    logic [1:0]  own;
    logic        uf;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam int NVEC = 29;
  vec_t tbl[NVEC];
  logic [31:0] skp4[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic [2:0] g,
                              input logic ov, input logic [31:0] od, input logic [3:0] ok,
                              input logic lv, input logic [31:0] ld,
                              input logic ordy, input logic lrdy,
                              input logic [31:0] d, input logic [3:0] k, input logic [1:0] h,
                              input logic vl, input logic [1:0] own, input logic uf);
    vec_t v;
    v.rst = rst; v.gen = g; v.os_v = ov; v.os_d = od; v.os_k = ok;
    v.ld_v = lv; v.ld_d = ld; v.os_rdy = ordy; v.ld_rdy = lrdy;
    v.data = d; v.k = k; v.hdr = h; v.vld = vl; v.own = own; v.uf = uf;
    return v;
  endfunction

  // Called at a falling edge; asserts reset, checks cleared outputs, releases two cycles later.
  task automatic do_reset();
    reset_n    = 1'b0;
    generation = 3'd4;
    os_valid   = 1'b1;
    ld_valid   = 1'b1;
    os_data    = '1;
    ld_data    = '1;
    os_datak   = '1;
    #1;
    chk("rst.data", sched_data, 32'h0);
    chk("rst.k", {28'h0, sched_datak}, 32'h0);
    chk("rst.hdr", {30'h0, sched_sync_header}, 32'h0);
    chk("rst.vld", {31'h0, sched_data_valid}, 32'h0);
    chk("rst.own", {30'h0, cur_owner}, 32'h0);
    chk("rst.uf", {31'h0, err_underflow}, 32'h0);
    chk("rst.os_ready", {31'h0, os_ready}, 32'h0);
    chk("rst.ld_ready", {31'h0, ld_ready}, 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    reset_n = 1'b1;
  endtask

  // One beat: drive at the falling edge, check readies, queue the expected beat, compare a cycle later.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    if (v.rst) do_reset();
    generation = v.gen;
    os_valid   = v.os_v;
    os_data    = v.os_d;
    os_datak   = v.os_k;
    ld_valid   = v.ld_v;
    ld_data    = v.ld_d;
    #1;
    chk({tag, ".os_ready"}, {31'h0, os_ready}, {31'h0, v.os_rdy});
    chk({tag, ".ld_ready"}, {31'h0, ld_ready}, {31'h0, v.ld_rdy});
    e.data = v.data; e.k = v.k; e.hdr = v.hdr; e.vld = v.vld; e.own = v.own; e.uf = v.uf;
    sbq.push_back(e);
    @(negedge pclk);
    e = sbq.pop_front();
    chk({tag, ".data"}, sched_data, e.data);
    chk({tag, ".k"}, {28'h0, sched_datak}, {28'h0, e.k});
    chk({tag, ".hdr"}, {30'h0, sched_sync_header}, {30'h0, e.hdr});
    chk({tag, ".vld"}, {31'h0, sched_data_valid}, {31'h0, e.vld});
    chk({tag, ".own"}, {30'h0, cur_owner}, {30'h0, e.own});
    chk({tag, ".uf"}, {31'h0, err_underflow}, {31'h0, e.uf});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    // ---- vector table ----
    // Disabled after reset: requester valid but nothing granted.
    tbl[0] = mk(1, 3'd0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 2'b00, 0, 2'd0, 0);
    // Gen4 link data streaming: header 10 every 4th beat.
    for (int i = 0; i < 8; i++) begin
      d = 32'hA500_0000 | 32'(i);
      tbl[1+i] = mk(0, 3'd4, 0, 0, 0, 1, d, 0, 1, d, 0,
                    (i % 4 == 0) ? 2'b10 : 2'b00, 1, 2'd3, 0);
    end
    // Gen3: OS and data requested together; OS block (K forced 0), then data block.
    for (int i = 0; i < 16; i++) begin
      if (i < 8)
        tbl[9+i] = mk(i == 0, 3'd3, 1, 32'hFFFF_4400 | 32'(i), 4'hF, 1, 32'hEEEE_5500 | 32'(i),
                      1, 0, 32'h0000_4400 | 32'(i), 0, (i == 0) ? 2'b01 : 2'b00, 1, 2'd2, 0);
      else
        tbl[9+i] = mk(0, 3'd3, 0, 32'h0, 4'h0, 1, 32'hEEEE_5500 | 32'(i),
                      0, 1, 32'h0000_5500 | 32'(i), 0, (i == 8) ? 2'b10 : 2'b00, 1, 2'd3, 0);
    end
    // Gen1 OS: one byte per beat, K passes through, no sync header.
    for (int i = 0; i < 4; i++) begin
      tbl[25+i] = mk(i == 0, 3'd1, 1, 32'h1234_56A0 | 32'(i), (i % 2 == 0) ? 4'hF : 4'hE, 0, 32'h0,
                     1, 0, 32'h0000_00A0 | 32'(i), (i % 2 == 0) ? 4'h1 : 4'h0, 2'b00, 1, 2'd2, 0);
    end

    skp4[0] = 32'hAAAA_AAAA;
    skp4[1] = 32'hAAAA_AAAA;
    skp4[2] = 32'hAAAA_AAAA;
    skp4[3] = 32'h0000_00E1;

    reset_n      = 1'b1;
    generation   = 3'd0;
    skp_interval = 11'd0;
    os_valid = 0; os_data = 0; os_datak = 0; ld_valid = 0; ld_data = 0;
    @(negedge pclk);

    for (int i = 0; i < NVEC; i++) step(tbl[i], $sformatf("vec%0d", i));

    // ---- Gen4 SKP every third block (interval 2) ----
    do_reset();
    skp_interval = 11'd2;
    for (int b = 0; b < 6; b++) begin
      for (int bt = 0; bt < 4; bt++) begin
        d = 32'h5100_0000 | 32'(b * 4 + bt);
        if (b % 3 == 2)
          step(mk(0, 3'd4, 0, 0, 0, 1, d, 0, 0, skp4[bt], 0,
                  (bt == 0) ? 2'b01 : 2'b00, 1, 2'd1, 0), $sformatf("skp4_b%0d_%0d", b, bt));
        else
          step(mk(0, 3'd4, 0, 0, 0, 1, d, 0, 1, d, 0,
                  (bt == 0) ? 2'b10 : 2'b00, 1, 2'd3, 0), $sformatf("skp4_b%0d_%0d", b, bt));
      end
    end

    // ---- Gen1 idle with SKP every fourth block (interval 3) ----
    do_reset();
    skp_interval = 11'd3;
    for (int b = 0; b < 8; b++) begin
      for (int bt = 0; bt < 4; bt++) begin
        if (b % 4 == 3)
          step(mk(0, 3'd1, 0, 0, 0, 0, 0, 0, 0, (bt == 0) ? 32'h0000_00BC : 32'h0000_001C, 4'h1,
                  2'b00, 1, 2'd1, 0), $sformatf("skp1_b%0d_%0d", b, bt));
        else
          step(mk(0, 3'd1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 2'b00, 1, 2'd0, 0),
               $sformatf("idle1_b%0d_%0d", b, bt));
      end
    end

    // ---- Gen3 underflow on beat 3, ownership kept ----
    do_reset();
    skp_interval = 11'd0;
    for (int bt = 0; bt < 9; bt++) begin
      d = 32'h7777_0300 | 32'(bt);
      if (bt == 3)
        step(mk(0, 3'd3, 0, 0, 0, 0, d, 0, 1, 32'h0, 0, 2'b00, 1, 2'd3, 1), "uf_b3");
      else
        step(mk(0, 3'd3, 0, 0, 0, 1, d, 0, 1, d & 32'h0000_FFFF, 0,
                (bt == 0 || bt == 8) ? 2'b10 : 2'b00, 1, 2'd3, 0), $sformatf("uf_b%0d", bt));
    end

    // ---- Mid-block generation change waits for the boundary ----
    do_reset();
    for (int bt = 0; bt < 6; bt++) begin
      d = 32'h9999_8800 | 32'(bt);
      step(mk(0, (bt < 2) ? 3'd4 : 3'd3, 0, 0, 0, 1, d, 0, 1,
              (bt < 4) ? d : (d & 32'h0000_FFFF), 0,
              (bt == 0 || bt == 4) ? 2'b10 : 2'b00, 1, 2'd3, 0), $sformatf("genchg_b%0d", bt));
    end

    // ---- Reset in the middle of a Gen3 OS block, then restart at beat 0 ----
    do_reset();
    for (int bt = 0; bt < 3; bt++) begin
      step(mk(0, 3'd3, 1, 32'h0000_6600 | 32'(bt), 0, 0, 0, 1, 0, 32'h0000_6600 | 32'(bt), 0,
              (bt == 0) ? 2'b01 : 2'b00, 1, 2'd2, 0), $sformatf("osrst_b%0d", bt));
    end
    do_reset();
    step(mk(0, 3'd3, 1, 32'h0000_6610, 0, 0, 0, 1, 0, 32'h0000_6610, 0, 2'b01, 1, 2'd2, 0), "restart_b0");
    step(mk(0, 3'd3, 1, 32'h0000_6611, 0, 0, 0, 1, 0, 32'h0000_6611, 0, 2'b00, 1, 2'd2, 0), "restart_b1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_block_scheduler.md
TX_BLOCK_SCHEDULER -- requirements
Module: tx_block_scheduler

Interface
REQ-001 SHALL have ports: pclk in 1 clock; reset_n in 1, reset asynchronous, active-low.
REQ-002 SHALL have generation in 3: link rate 1..5; any other value = disabled.
REQ-003 SHALL have skp_interval in 11: blocks between SKP blocks; 0 disables SKP.
REQ-004 SHALL have os_valid in 1, os_data in 32, os_datak in 4, os_ready out 1: ordered-set requester.
REQ-005 SHALL have ld_valid in 1, ld_data in 32, ld_ready out 1: link-data requester, K always 0.
REQ-006 SHALL have sched_data out 32, sched_datak out 4, sched_sync_header out 2, sched_data_valid out 1: stream to scrambler.
REQ-007 SHALL have cur_owner out 2 (0 idle, 1 SKP, 2 OS, 3 data) and err_underflow out 1 (one-cycle pulse).

Function
REQ-008 SHALL use bytes/beat W = 1 for gen1/2, 2 for gen3, 4 for gen4/5; unused high bytes of sched_data and unused sched_datak bits = 0.
REQ-009 SHALL use beats/block B = 4 for gen1/2 and 16/W for gen3+ (8 for gen3, 4 for gen4/5), tracked by beat_cnt 0..B-1 wrapping to 0.
REQ-010 SHALL arbitrate only at beat_cnt==0, priority SKP pending > os_valid > ld_valid > idle; the winner owns all B beats of the block.
REQ-011 SHALL use FSM states DISABLED, IDLE, SKP, OS, DATA; DISABLED while generation invalid; from any state, re-enter arbitration at the next beat_cnt==0.
REQ-012 SHALL latch generation only at block boundaries; a mid-block change takes effect at the next boundary.
REQ-013 SHALL drive os_ready/ld_ready combinationally high only in cycles where the owner is that source; a beat transfers when valid&&ready.
REQ-014 SHALL, if the owning source drops valid mid-block, output zero data/K for that beat, pulse err_underflow, and keep ownership to block end.
REQ-015 SHALL register all sched_* outputs: one cycle from accepted beat to output.
REQ-016 SHALL, in gen3+, set sched_sync_header on beat 0 only (OS/SKP = 2'b01, data/idle = 2'b10) and 2'b00 on other beats; in gen1/2 it SHALL always be 2'b00.
REQ-017 SHALL generate gen3+ SKP block bytes 0..11 = 0xAA, byte 12 = 0xE1, bytes 13..15 = 0x00, all K=0.
REQ-018 SHALL generate gen1/2 SKP bytes COM 0xBC, then 0x1C x3, each with K=1.
REQ-019 SHALL make an idle block all zero bytes with K=0.
REQ-020 SHALL assert sched_data_valid=1 on every enabled beat, and 0 in DISABLED.
REQ-021 SHALL have an 11-bit block counter that increments at each block end, sets skp_pending when it equals skp_interval (nonzero), and clears to 0 with skp_pending when an SKP block starts.
REQ-022 SHALL, if skp_pending sets while another block runs, let that block finish, then insert SKP.
REQ-023 SHALL pass os_datak through to sched_datak in gen1/2 and force it to 0 in gen3+.

Reset
REQ-024 SHALL clear asynchronously on reset_n low: sched_data 0, sched_datak 0, sched_sync_header 0, sched_data_valid 0, err_underflow 0, cur_owner 0, beat_cnt 0, block counter 0, skp_pending 0, FSM DISABLED.
REQ-025 SHALL force os_ready=ld_ready=0 during reset; after release, first arbitration at beat_cnt 0 on the first clock with valid generation.

Structure
REQ-026 SHALL define owner encodings, FSM state encodings, sync header constants (2'b01, 2'b10), and SKP symbol constants (0xAA, 0xE1, 0xBC, 0x1C) in shared package pcie_tx_pkg.
REQ-027 SHALL implement SKP generation as sub-module skp_block_gen (inputs generation, beat_cnt; outputs data/K for the beat).

Verification
REQ-028 Gen4, ld_valid held high, skp_interval 0 -> every 4th beat header 10, others 00; ld data appears 1 cycle later; ld_ready constant 1.
REQ-029 Gen3, os_valid and ld_valid rise same cycle at boundary -> OS owns 8 beats with header 01, then data block with header 10.
REQ-030 Gen4, skp_interval 2, ld_valid high -> after 2 data blocks, SKP block AA x12, E1, 00 x3, header 01; repeats every 3 blocks.
REQ-031 Gen1, skp_interval 3, idle -> after 3 idle blocks, bytes BC,1C,1C,1C with K=1 on consecutive beats.
REQ-032 Gen3, ld_valid drops on beat 3 -> beat 3 output 0, err_underflow pulse, next ld beat at beat 4 of same block.
REQ-033 reset_n low mid-OS block -> all outputs 0 immediately; after release, arbitration restarts at beat 0.
